// File: rtl/seq_bench_pkg.sv
// rtl/seq_bench_pkg.sv - shared state encoding, default MISR polynomial and width helper for seq_bench_gen
package seq_bench_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h8005;

    // Shift counter must be able to hold SR_DEPTH itself.
    function automatic int sc_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_bench_misr.sv
// rtl/seq_bench_misr.sv - multiple-input signature register compacting the core's state word
module seq_bench_misr #(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h8005
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [SIG_W-1:0] D,
    output logic [SIG_W-1:0] SIG
);

    logic [SIG_W-1:0] sig;

    always_ff @(posedge CK) begin
        if (RST) begin
            sig <= '0;
        end else begin
            sig <= (sig << 1) ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ D;
        end
    end

    assign SIG = sig;

endmodule

// File: rtl/seq_bench_gen.sv
// rtl/seq_bench_gen.sv - counter / shift register / 4-state FSM benchmark core; SEQ_BENCH_MISR_EN adds the signature MISR
module seq_bench_gen
    import seq_bench_pkg::*;
#(
    parameter int               CNT_W    = 4,
    parameter int               SR_DEPTH = 5,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                G0,
    input  logic                G1,
    input  logic                G2,
    output logic [CNT_W-1:0]    CNT,
    output logic [SR_DEPTH-1:0] SR,
    output logic [1:0]          STATE,
    output logic                TC,
    output logic [SIG_W-1:0]    SIG
);

    localparam int SC_W = sc_width(SR_DEPTH);

    if (CNT_W < 2 || SR_DEPTH < 2 || CNT_W + SR_DEPTH + 3 > SIG_W) begin : g_param_check
        $error("seq_bench_gen: illegal CNT_W/SR_DEPTH/SIG_W combination");
    end

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SR_DEPTH-1:0] sr, sr_nxt;
    logic [SC_W-1:0]     sc, sc_nxt;
    logic                tc, tc_nxt;
    logic                wrap, last_shift;

    assign wrap       = (state == COUNT) && G1 && (cnt == '1);
    assign last_shift = (state == SHIFT) && (sc == SC_W'(SR_DEPTH - 1));

    always_ff @(posedge CK) begin
        if (RST || G0) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (G1) state_nxt = COUNT;
            COUNT:   if (!G1) state_nxt = HOLD;
                     else if (cnt == '1) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = G1 ? COUNT : IDLE;
            HOLD:    if (G2) state_nxt = IDLE;
                     else if (G1) state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values; G1 is deliberately not consulted mid-SHIFT.
    always_comb begin
        cnt_nxt = cnt;
        sr_nxt  = sr;
        sc_nxt  = sc;
        tc_nxt  = wrap;
        if (state == COUNT && G1) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        if (state == SHIFT) begin
            sr_nxt = {sr[SR_DEPTH-2:0], G2};
            sc_nxt = last_shift ? '0 : sc + SC_W'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (RST || G0) begin
            cnt <= '0;
            sr  <= '0;
            sc  <= '0;
            tc  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sr  <= sr_nxt;
            sc  <= sc_nxt;
            tc  <= tc_nxt;
        end
    end

    assign CNT   = cnt;
    assign SR    = sr;
    assign STATE = state;
    assign TC    = tc;

`ifdef SEQ_BENCH_MISR_EN
    logic [SIG_W-1:0] misr_d;

    assign misr_d = SIG_W'({tc, state, sr, cnt});

    seq_bench_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .CK  (CK),
        .RST (RST),
        .D   (misr_d),
        .SIG (SIG)
    );
`else
    logic unused_poly;

    assign unused_poly = ^SIG_POLY;
    assign SIG         = '0;
`endif

endmodule

// File: tb/tb_seq_bench_gen.sv
// tb/tb_seq_bench_gen.sv - directed plus randomized checks of seq_bench_gen against a behavioural model
module tb_seq_bench_gen;

    localparam int          CNT_W    = 4;
    localparam int          SR_DEPTH = 5;
    localparam int          SIG_W    = 16;
    localparam logic [15:0] SIG_POLY = 16'h8005;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;
    localparam int          SR_MASK  = (1 << SR_DEPTH) - 1;
    localparam int          SIG_MASK = (1 << SIG_W) - 1;

    logic                CK = 1'b0;
    logic                RST = 1'b1;
    logic                G0 = 1'b0;
    logic                G1 = 1'b0;
    logic                G2 = 1'b0;
    logic [CNT_W-1:0]    CNT;
    logic [SR_DEPTH-1:0] SR;
    logic [1:0]          STATE;
    logic                TC;
    logic [SIG_W-1:0]    SIG;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0..3, remaining shift cycles counted down from SR_DEPTH.
    int m_mode, m_cnt, m_sr, m_tc, m_left, m_sig;

    seq_bench_gen #(
        .CNT_W    (CNT_W),
        .SR_DEPTH (SR_DEPTH),
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) dut (
        .CK    (CK),
        .RST   (RST),
        .G0    (G0),
        .G1    (G1),
        .G2    (G2),
        .CNT   (CNT),
        .SR    (SR),
        .STATE (STATE),
        .TC    (TC),
        .SIG   (SIG)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit g0, input bit g1, input bit g2);
        int d, nsig;
        d = (m_tc << (CNT_W + SR_DEPTH + 2)) | (m_mode << (CNT_W + SR_DEPTH))
            | (m_sr << CNT_W) | m_cnt;
        nsig = ((m_sig << 1) & SIG_MASK) ^ (((m_sig >> (SIG_W - 1)) & 1) != 0 ? int'(SIG_POLY) : 0) ^ d;
`ifdef SEQ_BENCH_MISR_EN
        m_sig = rst ? 0 : nsig;
`else
        m_sig = 0;
`endif
        if (rst || g0) begin
            m_mode = 0; m_cnt = 0; m_sr = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            case (m_mode)
                0: if (g1) m_mode = 1;
                1: begin
                    if (!g1) m_mode = 3;
                    else if (m_cnt == CNT_MAX) begin
                        m_cnt = 0; m_tc = 1; m_mode = 2; m_left = SR_DEPTH;
                    end else m_cnt = m_cnt + 1;
                end
                2: begin
                    m_sr = ((m_sr << 1) | int'(g2)) & SR_MASK;
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = g1 ? 1 : 0;
                end
                default: begin
                    if (g2) m_mode = 0;
                    else if (g1) m_mode = 1;
                end
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit g0, input bit g1, input bit g2);
        RST = rst; G0 = g0; G1 = g1; G2 = g2;
        @(posedge CK);
        model_step(rst, g0, g1, g2);
        #1;
        check("cnt", 32'(CNT), m_cnt);
        check("sr", 32'(SR), m_sr);
        check("state", 32'(STATE), m_mode);
        check("tc", 32'(TC), m_tc);
        check("sig", 32'(SIG), m_sig);
    endtask

    initial begin
        logic [4:0] pat;
        m_mode = 0; m_cnt = 0; m_sr = 0; m_tc = 0; m_left = 0; m_sig = 0;
        pat = 5'b10110;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_state", 32'(STATE), 0);
        check("reset_sig", 32'(SIG), 0);

        // Run to the wrap with G1 held.
        step(0, 0, 1, 0);
        check("t1_count", 32'(STATE), 1);
        for (int i = 0; i < CNT_MAX; i++) step(0, 0, 1, 0);
        check("t1_cnt_max", 32'(CNT), CNT_MAX);
        step(0, 0, 1, 0);
        check("t1_wrap_cnt", 32'(CNT), 0);
        check("t1_wrap_state", 32'(STATE), 2);
        check("t1_tc_pulse", 32'(TC), 1);

        for (int i = 0; i < SR_DEPTH; i++) begin
            step(0, 0, 1, pat[SR_DEPTH-1-i]);
            if (i == 0) check("t1_tc_drop", 32'(TC), 0);
        end
        check("t2_sr", 32'(SR), 32'h16);
        check("t2_state", 32'(STATE), 1);

        for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
        check("t3_cnt7", 32'(CNT), 7);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("t3_hold", 32'(STATE), 3);
        check("t3_frozen", 32'(CNT), 7);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("t3_resume_state", 32'(STATE), 1);
        check("t3_resume_cnt", 32'(CNT), 8);

        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        check("t4_abort", 32'(STATE), 0);

        for (int i = 0; i < 40 && m_mode != 2; i++) step(0, 0, 1, 0);
        check("t5_in_shift", 32'(STATE), 2);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        check("t5_sr_nonzero", 32'(SR != 0), 1);
        step(0, 1, 1, 1);
        check("t5_g0_cnt", 32'(CNT), 0);
        check("t5_g0_sr", 32'(SR), 0);
        check("t5_g0_state", 32'(STATE), 0);
        step(1, 1, 0, 0);
        check("t5_rst_sig", 32'(SIG), 0);

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
`ifdef SEQ_BENCH_MISR_EN
        check("t6_sig_nonzero", 32'(SIG != 0), 1);
`else
        check("t6_sig_zero", 32'(SIG), 0);
`endif

        // Mid-SHIFT reset then re-entry exercises the shift-count restart.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
